forklift_pass_ctrl: RTL and testbench

- Sequencer for the streaming forklift accessibility datapath.
- Holds a W×H paper-roll grid in a frame buffer and repeatedly streams it, row-major, through the external datapath.
- Clears every cell the datapath flags as accessible, and keeps running passes until a pass removes nothing.
- Reports the first-pass count, the total removed and the number of passes run.

---
 rtl/forklift_pkg.sv | 30 +++
 rtl/forklift_pass_ctrl_if.sv | 47 ++++
 rtl/forklift_frame_buf.sv | 39 +++
 rtl/forklift_pass_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_forklift_pass_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/forklift_pkg.sv
// Shared definitions for the forklift accessibility sequencer and its datapath.
//   state_e      : sequencer state encoding (also exposed on the debug bus)
//   DEF_W/DEF_H  : default grid geometry, CELLS = DEF_W*DEF_H
//   cnt_width()  : bits needed to count 0..n inclusive
//   idx_width()  : bits needed to index 0..n-1 (never less than 1)
package forklift_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_READY,
      S_PASS_RST,
      S_STREAM,
      S_CHECK,
      S_DONE
   } state_e;

   localparam int DEF_W = 10;
   localparam int DEF_H = 10;
   localparam int CELLS = DEF_W * DEF_H;

   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/forklift_pass_ctrl_if.sv
// Bus between the sequencer and its environment (loader, host, datapath).
// Handshakes:
//   load_valid/load_ready : a cell transfers on every cycle where both are high;
//                           the loader must hold load_cell stable while load_valid
//                           is high and load_ready is low.
//   dp_in_valid           : strobe only, no backpressure; dp_accessible answers
//                           combinationally in the same cycle for the cell presented
//                           LAG strobes earlier.
// Ports summary: control (clear, start), load stream, status (busy, done, error,
// counters), datapath stream (dp_rst, dp_in_valid, dp_cell, dp_accessible) and a
// debug view of the sequencer state (dbg_state).
interface forklift_pass_ctrl_if
   import forklift_pkg::*;
#(
   parameter int CNT_W = 7
);
   logic             clear;
   logic             load_valid;
   logic             load_cell;
   logic             load_ready;
   logic             start;
   logic             busy;
   logic             done;
   logic             error;
   logic             dp_rst;
   logic             dp_in_valid;
   logic             dp_cell;
   logic             dp_accessible;
   logic [CNT_W-1:0] first_removed;
   logic [CNT_W+7:0] total_removed;
   logic [7:0]       pass_count;
   state_e           dbg_state;

   // Sequencer side
   modport slave (
      input  clear, load_valid, load_cell, start, dp_accessible,
      output load_ready, busy, done, error, dp_rst, dp_in_valid, dp_cell,
             first_removed, total_removed, pass_count, dbg_state
   );

   // Environment side
   modport master (
      output clear, load_valid, load_cell, start, dp_accessible,
      input  load_ready, busy, done, error, dp_rst, dp_in_valid, dp_cell,
             first_removed, total_removed, pass_count, dbg_state
   );
endinterface

// File: rtl/forklift_frame_buf.sv
// Frame buffer holding the paper-roll grid, one bit per cell.
//   clk, rst  : clock, synchronous active-high reset (zeroes every cell)
//   clear     : zeroes every cell, same effect as rst
//   wr_*      : load write port
//   clr_*     : verdict clear port; kept separate from the load port so the two
//               never contend for one index
//   rd_idx    : combinational read port; rd_data = cell at rd_idx
module forklift_frame_buf #(
   parameter int CELLS = 100,
   parameter int IDX_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_data,
   input  logic             clr_en,
   input  logic [IDX_W-1:0] clr_idx,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_data
);
   logic [CELLS-1:0] mem_q;
   logic [CELLS-1:0] mem_d;

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_idx] = wr_data;
      if (clr_en) mem_d[clr_idx] = 1'b0;
      if (clear) mem_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) mem_q <= '0;
      else     mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_idx];
endmodule

// File: rtl/forklift_pass_ctrl.sv
// Sequencer for the streaming forklift accessibility datapath. Loads a W x H grid,
// then streams it row-major through the external datapath pass after pass,
// clearing each cell the datapath flags, until a pass removes nothing.
//   clk, rst : clock, synchronous active-high reset
//   bus      : forklift_pass_ctrl_if.slave (load stream, start/clear, status,
//              datapath stream, debug state)
module forklift_pass_ctrl
   import forklift_pkg::*;
#(
   parameter int W        = 10,
   parameter int H        = 10,
   parameter int LAG      = W + 1,
   parameter int MAX_PASS = 255,
   parameter int CNT_W    = cnt_width(W * H)
) (
   input  logic                  clk,
   input  logic                  rst,
   forklift_pass_ctrl_if.slave   bus
);
   localparam int NC     = W * H;
   localparam int IDX_W  = idx_width(NC);
   localparam int SIDX_W = idx_width(NC + LAG);
   localparam logic [SIDX_W-1:0] LAG_S   = SIDX_W'(LAG);
   localparam logic [SIDX_W-1:0] NC_S    = SIDX_W'(NC);
   localparam logic [SIDX_W-1:0] LAST_S  = SIDX_W'(NC + LAG - 1);
   localparam logic [CNT_W-1:0]  LAST_L  = CNT_W'(NC - 1);
   localparam logic [7:0]        MAXP_M1 = 8'(MAX_PASS - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    idx_q, idx_d;
   logic [SIDX_W-1:0]   sidx_q, sidx_d;
   logic [CNT_W-1:0]    pass_rm_q, pass_rm_d;
   logic [CNT_W-1:0]    first_q, first_d;
   logic [CNT_W+7:0]    total_q, total_d;
   logic [7:0]          pcnt_q, pcnt_d;
   logic                err_q, err_d;
   logic                done_q, done_d;

   logic                wr_en, clr_en, rd_data;
   logic                load_ready, busy, dp_valid, pass_rst;
   logic [SIDX_W-1:0]   v_s;
   logic                verdict_hit;

   // Verdict for cell v = sidx - LAG arrives while cell sidx is presented. The
   // clear lands behind the read pointer, and the datapath already holds every
   // neighbour of later cells, so each pass sees a snapshot of the grid.
   assign v_s         = sidx_q - LAG_S;
   assign verdict_hit = dp_valid && (sidx_q >= LAG_S) && (v_s < NC_S) && bus.dp_accessible;

   forklift_frame_buf #(.CELLS(NC), .IDX_W(IDX_W)) u_frame (
      .clk     (clk),
      .rst     (rst),
      .clear   (bus.clear),
      .wr_en   (wr_en),
      .wr_idx  (idx_q[IDX_W-1:0]),
      .wr_data (bus.load_cell),
      .clr_en  (clr_en),
      .clr_idx (v_s[IDX_W-1:0]),
      .rd_idx  (sidx_q[IDX_W-1:0]),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      sidx_d     = sidx_q;
      pass_rm_d  = pass_rm_q;
      first_d    = first_q;
      total_d    = total_q;
      pcnt_d     = pcnt_q;
      err_d      = err_q;
      done_d     = 1'b0;
      wr_en      = 1'b0;
      clr_en     = 1'b0;
      load_ready = 1'b0;
      busy       = 1'b0;
      dp_valid   = 1'b0;
      pass_rst   = 1'b0;
      unique case (state_q)
         S_IDLE, S_LOAD: begin
            load_ready = 1'b1;
            if (bus.load_valid) begin
               wr_en   = 1'b1;
               idx_d   = idx_q + 1'b1;
               state_d = (idx_q == LAST_L) ? S_READY : S_LOAD;
            end
         end
         S_READY, S_DONE: begin
            if (bus.start) begin
               state_d   = S_PASS_RST;
               pass_rm_d = '0;
               total_d   = '0;
               pcnt_d    = '0;
               first_d   = '0;
            end
         end
         S_PASS_RST: begin
            busy      = 1'b1;
            pass_rst  = 1'b1;
            sidx_d    = '0;
            pass_rm_d = '0;
            state_d   = S_STREAM;
         end
         S_STREAM: begin
            busy     = 1'b1;
            dp_valid = 1'b1;
            sidx_d   = sidx_q + 1'b1;
            if (verdict_hit) begin
               clr_en    = 1'b1;
               pass_rm_d = pass_rm_q + 1'b1;
            end
            if (sidx_q == LAST_S) state_d = S_CHECK;
         end
         S_CHECK: begin
            busy    = 1'b1;
            pcnt_d  = pcnt_q + 8'd1;
            total_d = total_q + {8'd0, pass_rm_q};
            if (pcnt_q == 8'd0) first_d = pass_rm_q;
            if (pass_rm_q == '0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (pcnt_q == MAXP_M1) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               state_d = S_PASS_RST;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // clear outranks start and drops any coincident load cell
      if (bus.clear) begin
         state_d   = S_IDLE;
         idx_d     = '0;
         sidx_d    = '0;
         pass_rm_d = '0;
         first_d   = '0;
         total_d   = '0;
         pcnt_d    = '0;
         err_d     = 1'b0;
         done_d    = 1'b0;
         wr_en     = 1'b0;
         clr_en    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         sidx_q    <= '0;
         pass_rm_q <= '0;
         first_q   <= '0;
         total_q   <= '0;
         pcnt_q    <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         sidx_q    <= sidx_d;
         pass_rm_q <= pass_rm_d;
         first_q   <= first_d;
         total_q   <= total_d;
         pcnt_q    <= pcnt_d;
         err_q     <= err_d;
         done_q    <= done_d;
      end
   end

   assign bus.load_ready    = load_ready;
   assign bus.busy          = busy;
   assign bus.done          = done_q;
   assign bus.error         = err_q;
   assign bus.dp_rst        = rst | pass_rst;
   assign bus.dp_in_valid   = dp_valid;
   assign bus.dp_cell       = dp_valid && (sidx_q < NC_S) && rd_data;
   assign bus.first_removed = first_q;
   assign bus.total_removed = total_q;
   assign bus.pass_count    = pcnt_q;
   assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_forklift_pass_ctrl.sv
// Bench for forklift_pass_ctrl: a 10x10 default instance (A) and a 4x4 instance
// with MAX_PASS=1 (B). Each has a behavioural golden datapath; expected results
// come from a whole-grid round-by-round model and are matched on done.
module tb_forklift_pass_ctrl;
   import forklift_pkg::*;

   localparam int EXP_W = 34;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear = 1'b0;
   logic load_valid = 1'b0;
   logic load_cell = 1'b0;
   logic start = 1'b0;
   logic sel = 1'b0;
   logic acc_a = 1'b0;
   logic acc_b = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [EXP_W-1:0] exp_q[$];

   logic [255:0] grid_a = '0, grid_b = '0;
   bit sticky_a = 1'b0, sticky_b = 1'b0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   forklift_pass_ctrl_if #(.CNT_W(7)) if_a ();
   forklift_pass_ctrl_if #(.CNT_W(5)) if_b ();

   forklift_pass_ctrl #(.W(10), .H(10), .LAG(11), .MAX_PASS(255)) dut_a (
      .clk (clk), .rst (rst), .bus (if_a)
   );
   forklift_pass_ctrl #(.W(4), .H(4), .LAG(5), .MAX_PASS(1)) dut_b (
      .clk (clk), .rst (rst), .bus (if_b)
   );

   assign if_a.clear         = clear;
   assign if_a.load_valid    = load_valid & ~sel;
   assign if_a.load_cell     = load_cell;
   assign if_a.start         = start & ~sel;
   assign if_a.dp_accessible = acc_a;
   assign if_b.clear         = clear;
   assign if_b.load_valid    = load_valid & sel;
   assign if_b.load_cell     = load_cell;
   assign if_b.start         = start & sel;
   assign if_b.dp_accessible = acc_b;

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int nbrs(input logic [255:0] g, input int idx, input int w, input int h);
      int r = idx / w;
      int c = idx % w;
      int n = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < h && c + dc >= 0 && c + dc < w)
               n += int'(g[(r + dr) * w + c + dc]);
      return n;
   endfunction

   // Whole-grid reference: remove every roll with fewer than 4 neighbouring rolls
   // simultaneously, repeat until a round removes nothing or the pass limit hits.
   task automatic ref_run(input logic [255:0] g, input int w, input int h, input int maxp,
                          output int first, output int total, output int passes,
                          output bit err, output logic [255:0] gout);
      logic [255:0] rm;
      int n;
      first = 0; total = 0; passes = 0; err = 1'b0; gout = g;
      while (1) begin
         rm = '0; n = 0;
         for (int i = 0; i < w * h; i++)
            if (gout[i] && nbrs(gout, i, w, h) < 4) begin
               rm[i] = 1'b1;
               n++;
            end
         gout = gout & ~rm;
         passes++;
         total += n;
         if (passes == 1) first = n;
         if (n == 0) break;
         if (passes == maxp) begin
            err = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- golden datapaths ----------------
   logic [255:0] gbuf_a = '0, gbuf_b = '0;
   int gcnt_a = 0, gcnt_b = 0;

   always @(negedge clk) begin
      int v;
      if (if_a.dp_rst) begin
         gcnt_a = 0;
         acc_a = 1'($urandom_range(0, 1));
      end else if (if_a.dp_in_valid) begin
         gbuf_a[gcnt_a] = if_a.dp_cell;
         v = gcnt_a - 11;
         if (v >= 0 && v < 100) acc_a = gbuf_a[v] && (nbrs(gbuf_a, v, 10, 10) < 4);
         else acc_a = 1'($urandom_range(0, 1));
         gcnt_a++;
      end else begin
         acc_a = 1'($urandom_range(0, 1));
      end
   end

   always @(negedge clk) begin
      int v;
      if (if_b.dp_rst) begin
         gcnt_b = 0;
         acc_b = 1'($urandom_range(0, 1));
      end else if (if_b.dp_in_valid) begin
         gbuf_b[gcnt_b] = if_b.dp_cell;
         v = gcnt_b - 5;
         if (v >= 0 && v < 16) acc_b = gbuf_b[v] && (nbrs(gbuf_b, v, 4, 4) < 4);
         else acc_b = 1'($urandom_range(0, 1));
         gcnt_b++;
      end else begin
         acc_b = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- scoreboard monitor ----------------
   logic [EXP_W-1:0] mon_e, mon_act;
   always @(negedge clk) begin
      if (!rst && (if_a.done || if_b.done)) begin
         if (if_a.done)
            mon_act = {1'b0, if_a.error, if_a.pass_count, 16'(if_a.total_removed), 8'(if_a.first_removed)};
         else
            mon_act = {1'b1, if_b.error, if_b.pass_count, 16'(if_b.total_removed), 8'(if_b.first_removed)};
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("done_dut",      64'(mon_act[33]),    64'(mon_e[33]));
            check("error",         64'(mon_act[32]),    64'(mon_e[32]));
            check("pass_count",    64'(mon_act[31:24]), 64'(mon_e[31:24]));
            check("total_removed", 64'(mon_act[23:8]),  64'(mon_e[23:8]));
            check("first_removed", 64'(mon_act[7:0]),   64'(mon_e[7:0]));
         end
      end
   end

   // Cadence on instance A: each stream burst is CELLS+LAG strobes, each
   // datapath reset between passes is a single cycle.
   int vrun = 0, rrun = 0;
   bit cad_skip = 1'b1;
   always @(negedge clk) begin
      if (rst || clear) begin
         vrun = 0; rrun = 0; cad_skip = 1'b1;
      end else begin
         if (if_a.dp_in_valid) vrun++;
         else if (vrun != 0) begin
            if (!cad_skip) check("valid_run", 64'(vrun), 111);
            vrun = 0;
         end
         if (if_a.dp_rst) rrun++;
         else if (rrun != 0) begin
            if (!cad_skip) check("dp_rst_run", 64'(rrun), 1);
            rrun = 0;
         end
         if (!if_a.dp_in_valid && !if_a.dp_rst) cad_skip = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      grid_a = '0; grid_b = '0;
      sticky_a = 1'b0; sticky_b = 1'b0;
   endtask

   task automatic load_grid(input logic [255:0] g);
      int n = sel ? 16 : 100;
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(0, 3) == 0) begin
            load_valid = 1'b0;
            tick();
         end
         load_valid = 1'b1;
         load_cell  = g[i];
         tick();
      end
      load_valid = 1'b0;
      if (sel) grid_b = g; else grid_a = g;
      check("state_ready", 64'(sel ? if_b.dbg_state : if_a.dbg_state), 64'(S_READY));
      check("load_ready_low", 64'(sel ? if_b.load_ready : if_a.load_ready), 0);
   endtask

   task automatic run();
      int first, total, passes;
      bit err;
      logic [255:0] gout;
      bit got = 1'b0;
      if (sel) begin
         ref_run(grid_b, 4, 4, 1, first, total, passes, err, gout);
         grid_b = gout;
         sticky_b = sticky_b | err;
         err = sticky_b;
      end else begin
         ref_run(grid_a, 10, 10, 255, first, total, passes, err, gout);
         grid_a = gout;
         sticky_a = sticky_a | err;
         err = sticky_a;
      end
      exp_q.push_back({sel, err, 8'(passes), 16'(total), 8'(first)});
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 20000 && !got; k++) begin
         tick();
         got = sel ? if_b.done : if_a.done;
      end
      if (!got) begin
         check("done_timeout", 0, 1);
         exp_q.delete();
      end
      tick();
      check("done_pulse_width", 64'(sel ? if_b.done : if_a.done), 0);
   endtask

   function automatic logic [255:0] rand_grid(input int n, input int dens);
      logic [255:0] g = '0;
      for (int i = 0; i < n; i++) g[i] = ($urandom_range(0, 99) < dens);
      return g;
   endfunction

   function automatic logic [255:0] block4();
      logic [255:0] g = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) g[r * 10 + c] = 1'b1;
      return g;
   endfunction

   // ---------------- main sequence ----------------
   logic [255:0] g;
   initial begin
      bit found;
      rst = 1'b1;
      repeat (3) tick();
      check("dp_rst_in_reset", 64'(if_a.dp_rst), 1);
      check("valid_in_reset", 64'(if_a.dp_in_valid), 0);
      rst = 1'b0;
      tick();
      check("rst_state_a", 64'(if_a.dbg_state), 64'(S_IDLE));
      check("rst_load_ready_a", 64'(if_a.load_ready), 1);
      check("rst_busy_a", 64'(if_a.busy), 0);
      check("rst_done_a", 64'(if_a.done), 0);
      check("rst_error_a", 64'(if_a.error), 0);
      check("rst_dp_rst_a", 64'(if_a.dp_rst), 0);
      check("rst_pass_count_a", 64'(if_a.pass_count), 0);
      check("rst_total_a", 64'(if_a.total_removed), 0);
      check("rst_state_b", 64'(if_b.dbg_state), 64'(S_IDLE));
      check("rst_error_b", 64'(if_b.error), 0);

      // start ignored in IDLE
      sel = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      check("start_idle_ignored", 64'(if_a.dbg_state), 64'(S_IDLE));
      check("start_idle_busy", 64'(if_a.busy), 0);

      // start ignored in LOAD; load coinciding with clear is dropped
      for (int i = 0; i < 5; i++) begin
         load_valid = 1'b1; load_cell = 1'b1; tick();
      end
      load_valid = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      check("start_load_ignored", 64'(if_a.dbg_state), 64'(S_LOAD));
      load_valid = 1'b1; clear = 1'b1; tick();
      load_valid = 1'b0; clear = 1'b0;
      check("clear_drops_load", 64'(if_a.dbg_state), 64'(S_IDLE));
      grid_a = '0; sticky_a = 1'b0; grid_b = '0; sticky_b = 1'b0;

      // empty grid, then restart from DONE
      load_grid('0);
      run();
      run();

      // 4x4 roll block: corners go in pass 1, nothing after
      do_clear();
      load_grid(block4());
      run();

      // single isolated roll at (1,1); restart shows the frame is empty
      do_clear();
      g = '0; g[11] = 1'b1;
      load_grid(g);
      run();
      run();

      // random grids, each followed by a restart on the reduced grid
      for (int t = 0; t < 4; t++) begin
         do_clear();
         load_grid(rand_grid(100, $urandom_range(40, 85)));
         run();
         run();
      end

      // rst during STREAM of pass 2 aborts; rerun matches an unbroken run
      do_clear();
      load_grid(block4());
      start = 1'b1; tick(); start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         tick();
         found = (if_a.dbg_state == S_STREAM) && (if_a.pass_count == 8'd1);
      end
      check("reach_pass2_stream", 64'(found), 1);
      repeat ($urandom_range(1, 80)) tick();
      rst = 1'b1;
      tick();
      check("abort_dp_rst", 64'(if_a.dp_rst), 1);
      rst = 1'b0;
      grid_a = '0; sticky_a = 1'b0; grid_b = '0; sticky_b = 1'b0;
      check("abort_state", 64'(if_a.dbg_state), 64'(S_IDLE));
      check("abort_load_ready", 64'(if_a.load_ready), 1);
      check("abort_busy", 64'(if_a.busy), 0);
      check("abort_pass_count", 64'(if_a.pass_count), 0);
      check("abort_total", 64'(if_a.total_removed), 0);
      check("abort_first", 64'(if_a.first_removed), 0);
      load_grid(block4());
      run();

      // instance B: 4x4, MAX_PASS=1
      sel = 1'b1;
      do_clear();
      load_grid({240'd0, 16'hffff});
      run();
      run();
      do_clear();
      load_grid(rand_grid(16, $urandom_range(30, 90)));
      run();

      tick();
      check("queue_drained", 64'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
